stack_unit: RTL and testbench

- Hardware LIFO stack for the 8-bit single-cycle CPU. It sits directly downstream of the control unit and consumes its stack_w_en / stack_r_en strobes.
- Push data comes from the register-file read port (reg_data0).
- Top-of-stack (tos) feeds the register write-back mux, so a pop writes the destination register on the same clock edge.
- Overflow and underflow are recorded as sticky error flags.

---
 rtl/cpu_stack_pkg.sv | 21 ++
 rtl/stack_ram.sv | 24 ++
 rtl/stack_unit.sv | 134 +++++++++++++
 tb/tb_stack_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cpu_stack_pkg.sv
// Shared types and sizing for the CPU hardware stack.
package cpu_stack_pkg;

   localparam int STACK_DATA_W = 8;
   localparam int STACK_DEPTH  = 8;

   // Operation actually performed this cycle, decoded from {push, pop, empty}
   typedef enum logic [1:0] {
      SOP_NOP,
      SOP_PUSH,
      SOP_POP,
      SOP_REPLACE
   } stack_op_e;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PARTIAL,
      ST_FULL
   } stack_state_e;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: synchronous write, asynchronous read, contents not reset.
module stack_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack for the 8-bit CPU: push/pop/replace, sticky overflow/underflow.
// Optional high-water mark output hwm when STACK_WATERMARK_EN is defined.
//
// state      | meaning
// -----------+------------------------------------------
// ST_EMPTY   | count == 0, tos reads as 0
// ST_PARTIAL | 0 < count < DEPTH (a single value when DEPTH == 2)
// ST_FULL    | count == DEPTH, further pushes overflow
module stack_unit
   import cpu_stack_pkg::*;
#(
   parameter int DATA_W = STACK_DATA_W,
   parameter int DEPTH  = STACK_DEPTH,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] tos,
   output logic [PTR_W:0]    count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
`ifdef STACK_WATERMARK_EN
   ,
   output logic [PTR_W:0]    hwm
`endif
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

   stack_state_e      state_q, state_d;
   stack_op_e         op;
   logic [PTR_W:0]    count_q, count_d, cnt_m1;
   logic              we;
   logic [PTR_W-1:0]  waddr;
   logic [DATA_W-1:0] rdata;
   logic              ovf_set, unf_set;

   assign cnt_m1 = count_q - ONE_CNT;
   assign empty  = (state_q == ST_EMPTY);
   assign full   = (state_q == ST_FULL);
   assign count  = count_q;
   assign tos    = empty ? '0 : rdata;

   // Decode the request into the operation that is actually carried out
   always_comb begin
      op      = SOP_NOP;
      unf_set = 1'b0;
      unique case ({push, pop})
         2'b10: op = SOP_PUSH;
         2'b01: op = SOP_POP;
         2'b11: begin
            // Replace on an empty stack degrades to a push but still flags underflow
            op      = empty ? SOP_PUSH : SOP_REPLACE;
            unf_set = empty;
         end
         default: op = SOP_NOP;
      endcase
   end

   // Next-state, next-count and write-port control
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we      = 1'b0;
      waddr   = count_q[PTR_W-1:0];
      ovf_set = 1'b0;
      case (op)
         SOP_PUSH: begin
            if (full) begin
               ovf_set = 1'b1;
            end else begin
               we      = 1'b1;
               count_d = count_q + ONE_CNT;
               state_d = (count_q == FULL_CNT - ONE_CNT) ? ST_FULL : ST_PARTIAL;
            end
         end
         SOP_POP: begin
            if (!empty) begin
               count_d = cnt_m1;
               state_d = (count_q == ONE_CNT) ? ST_EMPTY : ST_PARTIAL;
            end
         end
         SOP_REPLACE: begin
            we    = 1'b1;
            waddr = cnt_m1[PTR_W-1:0];
         end
         default: ;
      endcase
   end

   // State, count and sticky error flags; a new error wins over clr_err
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         count_q   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         overflow  <= ovf_set | (overflow & ~clr_err);
         underflow <= unf_set | (underflow & ~clr_err) | (op == SOP_POP && empty);
      end
   end

`ifdef STACK_WATERMARK_EN
   // High-water mark follows count upward; only reset clears it
   always_ff @(posedge clk) begin
      if (rst)                 hwm <= '0;
      else if (count_d > hwm)  hwm <= count_d;
   end
`endif

   stack_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (we & ~rst),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (cnt_m1[PTR_W-1:0]),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: driver queues expected post-edge state,
// monitor compares on the falling edge. Define STACK_WATERMARK_EN to check hwm.
module tb_stack_unit;

   logic       clk = 1'b0;
   logic       rst, push, pop, clr_err;
   logic [7:0] wdata;
   logic [7:0] tos;
   logic [3:0] count;
   logic       empty, full, overflow, underflow;
`ifdef STACK_WATERMARK_EN
   logic [3:0] hwm;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      int cnt;
      int tos;
      int ovf;
      int unf;
      int hwm;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   stack_unit dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .wdata     (wdata),
      .tos       (tos),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow),
      .clr_err   (clr_err)
`ifdef STACK_WATERMARK_EN
      ,
      .hwm       (hwm)
`endif
   );

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   // One clock of stimulus; expected state after the edge goes to the scoreboard
   task automatic step(input logic pu, input logic po, input logic [7:0] wd,
                       input logic ce, input logic rs, input int ec, input int et,
                       input int eo, input int eu, input int eh = -1);
      exp_t e;
      @(negedge clk);
      push = pu; pop = po; wdata = wd; clr_err = ce; rst = rs;
      @(posedge clk);
      #1;
      e.cnt = ec; e.tos = et; e.ovf = eo; e.unf = eu; e.hwm = eh;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are state-only, so the falling edge is a stable sample point
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", int'(count), e.cnt);
            chk("tos", int'(tos), e.tos);
            chk("empty", int'(empty), (e.cnt == 0) ? 1 : 0);
            chk("full", int'(full), (e.cnt == 8) ? 1 : 0);
            chk("overflow", int'(overflow), e.ovf);
            chk("underflow", int'(underflow), e.unf);
`ifdef STACK_WATERMARK_EN
            if (e.hwm >= 0) chk("hwm", int'(hwm), e.hwm);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; wdata = 8'h00; clr_err = 1'b0;
      //   pu po wd     ce rs  cnt tos    ovf unf
      step(0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
      // basic LIFO order
      step(1, 0, 8'h11, 0, 0,  1, 8'h11, 0, 0);
      step(1, 0, 8'h22, 0, 0,  2, 8'h22, 0, 0);
      step(1, 0, 8'h33, 0, 0,  3, 8'h33, 0, 0);
      step(0, 1, 8'h00, 0, 0,  2, 8'h22, 0, 0);
      step(0, 1, 8'h00, 0, 0,  1, 8'h11, 0, 0);
      step(0, 1, 8'h00, 0, 0,  0, 8'h00, 0, 0);
      // replace on a non-empty stack, then push+pop on empty
      step(1, 0, 8'h11, 0, 0,  1, 8'h11, 0, 0);
      step(1, 0, 8'h22, 0, 0,  2, 8'h22, 0, 0);
      step(1, 1, 8'h5C, 0, 0,  2, 8'h5C, 0, 0);
      step(0, 1, 8'h00, 0, 0,  1, 8'h11, 0, 0);
      step(0, 1, 8'h00, 0, 0,  0, 8'h00, 0, 0);
      step(1, 1, 8'h7E, 0, 0,  1, 8'h7E, 0, 1);
      step(0, 0, 8'h00, 1, 0,  1, 8'h7E, 0, 0);
      step(0, 1, 8'h00, 0, 0,  0, 8'h00, 0, 0);
      // pop on empty with clr_err: the new error wins
      step(0, 1, 8'h00, 1, 0,  0, 8'h00, 0, 1);
      step(0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
      // fill, overflow, clear, replace while full, then drain
      for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), 0, 0, i, i, 0, 0);
      step(1, 0, 8'hAA, 0, 0,  8, 8'h08, 1, 0);
      step(0, 0, 8'h00, 1, 0,  8, 8'h08, 0, 0);
      step(1, 1, 8'h99, 0, 0,  8, 8'h99, 0, 0);
      for (int i = 7; i >= 0; i--) step(0, 1, 8'h00, 0, 0, i, i, 0, 0);
      // reset beats a simultaneous push and clears sticky flags
      step(0, 1, 8'h00, 0, 0,  0, 8'h00, 0, 1);
      step(1, 0, 8'hC1, 0, 0,  1, 8'hC1, 0, 1);
      step(1, 0, 8'hC2, 0, 0,  2, 8'hC2, 0, 1);
      step(1, 0, 8'hC3, 0, 0,  3, 8'hC3, 0, 1);
      step(1, 0, 8'hC4, 0, 0,  4, 8'hC4, 0, 1);
      step(1, 0, 8'hC5, 0, 0,  5, 8'hC5, 0, 1);
      step(1, 0, 8'hC6, 0, 1,  0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
      // watermark: push 5, pop 3, push 1, then reset
      step(0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0);
      for (int i = 1; i <= 5; i++) step(1, 0, 8'(8'h40 + i), 0, 0, i, 8'h40 + i, 0, 0, i);
      step(0, 1, 8'h00, 0, 0,  4, 8'h44, 0, 0, 5);
      step(0, 1, 8'h00, 0, 0,  3, 8'h43, 0, 0, 5);
      step(0, 1, 8'h00, 0, 0,  2, 8'h42, 0, 0, 5);
      step(1, 0, 8'h50, 0, 0,  3, 8'h50, 0, 0, 5);
      step(0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0);
      @(negedge clk);
      push = 1'b0; pop = 1'b0; rst = 1'b0; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
